// File: rtl/alu_unit.sv
// 8-bit registered ALU for the execute stage: result and zero flag are
// captured one clock after the operands and opcode are presented.
module alu_unit (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [4:0] OP,
    input  logic [7:0] inOne,
    input  logic [7:0] inTwo,
    output logic [7:0] res,
    output logic       ZERO
);

    localparam logic [4:0] OP_ADD  = 5'b00000;
    localparam logic [4:0] OP_SUB  = 5'b00001;
    localparam logic [4:0] OP_SLL  = 5'b00010;
    localparam logic [4:0] OP_SRL  = 5'b00011;
    localparam logic [4:0] OP_SLT  = 5'b00111;
    localparam logic [4:0] OP_SUBU = 5'b01000;
    localparam logic [4:0] OP_ADDU = 5'b01001;
    localparam logic [4:0] OP_AND  = 5'b01010;
    localparam logic [4:0] OP_SEZ  = 5'b01011;
    localparam logic [4:0] OP_SEQ  = 5'b01100;
    localparam logic [4:0] OP_MOD  = 5'b01111;

    logic [7:0] res_d;
    logic [7:0] res_q;
    logic       zero_d;
    logic       zero_q;
    logic [7:0] mod_rem;

    // Restoring remainder, one trial subtraction per dividend bit.
    always_comb begin
        logic [8:0] rem;
        rem = 9'd0;
        for (int i = 7; i >= 0; i--) begin
            rem = {rem[7:0], inOne[i]};
            if (rem >= {1'b0, inTwo}) begin
                rem = rem - {1'b0, inTwo};
            end
        end
        mod_rem = (inTwo == 8'd0) ? inOne : rem[7:0];
    end

    always_comb begin
        res_d = 8'd0;
        if (OP[4:2] == 3'b100) begin
            res_d = inOne + inTwo;
        end else begin
            case (OP)
                OP_ADD, OP_ADDU: res_d = inOne + inTwo;
                OP_SUB, OP_SUBU: res_d = inOne - inTwo;
                OP_SLL:          res_d = inOne << inTwo;
                OP_SRL:          res_d = inOne >> inTwo;
                OP_SLT:          res_d = {7'd0, $signed(inOne) < $signed(inTwo)};
                OP_AND:          res_d = inOne & inTwo;
                OP_SEZ:          res_d = {7'd0, inOne == 8'd0};
                OP_SEQ:          res_d = {7'd0, inOne == inTwo};
                OP_MOD:          res_d = mod_rem;
                default:         res_d = 8'd0;
            endcase
        end
        zero_d = (res_d == 8'd0);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            res_q  <= 8'h00;
            zero_q <= 1'b1;
        end else begin
            res_q  <= res_d;
            zero_q <= zero_d;
        end
    end

    assign res  = res_q;
    assign ZERO = zero_q;

endmodule

// File: tb/tb_alu_unit.sv
// Self-checking bench for alu_unit: directed vector table, reset and
// timing sequences, back-to-back ops and randomized reference-model checks.
module tb_alu_unit;

    logic       CLK;
    logic       RST_N;
    logic [4:0] OP;
    logic [7:0] inOne;
    logic [7:0] inTwo;
    logic [7:0] res;
    logic       ZERO;

    int errors = 0;
    int checks = 0;

    alu_unit dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .OP    (OP),
        .inOne (inOne),
        .inTwo (inTwo),
        .res   (res),
        .ZERO  (ZERO)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, res=%02h ZERO=%0b", res, ZERO);
        $fatal(1, "timeout");
    end

    typedef struct {
        string      name;
        logic [4:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp_res;
        logic       exp_zero;
    } vec_t;

    vec_t vecs[21];

    // Reference model written from the operation rules with integer arithmetic.
    function automatic logic [7:0] ref_alu(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia, ib, sa, sb, r;
        ia = int'(a);
        ib = int'(b);
        sa = (ia > 127) ? ia - 256 : ia;
        sb = (ib > 127) ? ib - 256 : ib;
        r  = 0;
        if (op[4:2] == 3'b100) r = ia + ib;
        else begin
            case (op)
                5'd0, 5'd9:  r = ia + ib;
                5'd1, 5'd8:  r = ia - ib + 256;
                5'd2:        r = (ib >= 8) ? 0 : ia * (1 << ib);
                5'd3:        r = (ib >= 8) ? 0 : ia / (1 << ib);
                5'd7:        r = (sa < sb) ? 1 : 0;
                5'd10:       r = int'(a & b);
                5'd11:       r = (ia == 0) ? 1 : 0;
                5'd12:       r = (ia == ib) ? 1 : 0;
                5'd15:       r = (ib == 0) ? ia : ia % ib;
                default:     r = 0;
            endcase
        end
        return 8'(r % 256);
    endfunction

    task automatic check(input string name, input logic [7:0] exp_res, input logic exp_zero);
        checks++;
        if (res !== exp_res || ZERO !== exp_zero) begin
            errors++;
            $display("FAIL %s: got res=%02h ZERO=%0b, expected res=%02h ZERO=%0b",
                     name, res, ZERO, exp_res, exp_zero);
        end
    endtask

    task automatic apply(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge CLK);
        OP    = op;
        inOne = a;
        inTwo = b;
    endtask

    initial begin
        logic [7:0] exp_q[$];
        logic [7:0] e;

        vecs[0]  = '{"add",      5'b00000, 8'h01, 8'h02, 8'h03, 1'b0};
        vecs[1]  = '{"sub",      5'b00001, 8'h01, 8'h02, 8'hFF, 1'b0};
        vecs[2]  = '{"subu",     5'b01000, 8'h01, 8'h82, 8'h7F, 1'b0};
        vecs[3]  = '{"addu",     5'b01001, 8'h01, 8'h02, 8'h03, 1'b0};
        vecs[4]  = '{"addi",     5'b10011, 8'h01, 8'h02, 8'h03, 1'b0};
        vecs[5]  = '{"add_wrap", 5'b00000, 8'hFF, 8'h01, 8'h00, 1'b1};
        vecs[6]  = '{"sll",      5'b00010, 8'h01, 8'h02, 8'h04, 1'b0};
        vecs[7]  = '{"srl",      5'b00011, 8'h08, 8'h02, 8'h02, 1'b0};
        vecs[8]  = '{"sll_8",    5'b00010, 8'h01, 8'h08, 8'h00, 1'b1};
        vecs[9]  = '{"srl_7",    5'b00011, 8'h80, 8'h07, 8'h01, 1'b0};
        vecs[10] = '{"slt_neg_b",5'b00111, 8'h01, 8'h82, 8'h00, 1'b1};
        vecs[11] = '{"slt_neg_a",5'b00111, 8'h82, 8'h01, 8'h01, 1'b0};
        vecs[12] = '{"seq_ne",   5'b01100, 8'h05, 8'h02, 8'h00, 1'b1};
        vecs[13] = '{"seq_eq",   5'b01100, 8'h07, 8'h07, 8'h01, 1'b0};
        vecs[14] = '{"sez_nz",   5'b01011, 8'h01, 8'h33, 8'h00, 1'b1};
        vecs[15] = '{"sez_z",    5'b01011, 8'h00, 8'h33, 8'h01, 1'b0};
        vecs[16] = '{"and",      5'b01010, 8'h01, 8'h02, 8'h00, 1'b1};
        vecs[17] = '{"mod_small",5'b01111, 8'h01, 8'h02, 8'h01, 1'b0};
        vecs[18] = '{"mod",      5'b01111, 8'h0D, 8'h04, 8'h01, 1'b0};
        vecs[19] = '{"mod_zero", 5'b01111, 8'h09, 8'h00, 8'h09, 1'b0};
        vecs[20] = '{"undef",    5'b00101, 8'h5A, 8'h11, 8'h00, 1'b1};

        RST_N = 1'b0;
        OP    = 5'b00000;
        inOne = 8'h01;
        inTwo = 8'h02;
        #12;
        check("reset_state", 8'h00, 1'b1);
        @(negedge CLK);
        RST_N = 1'b1;

        // Table-driven directed vectors, each checked one edge after apply.
        foreach (vecs[i]) begin
            apply(vecs[i].op, vecs[i].a, vecs[i].b);
            @(posedge CLK);
            #1;
            check(vecs[i].name, vecs[i].exp_res, vecs[i].exp_zero);
        end

        // Inputs changing between edges must not disturb the registered output.
        apply(5'b00000, 8'h01, 8'h02);
        @(posedge CLK);
        #1;
        OP    = 5'b00001;
        inOne = 8'h40;
        inTwo = 8'h10;
        #2;
        check("hold_between_edges", 8'h03, 1'b0);
        @(posedge CLK);
        #1;
        check("capture_after_change", 8'h30, 1'b0);

        // Asynchronous reset mid-cycle while res=03, held through an edge.
        apply(5'b00000, 8'h01, 8'h02);
        @(posedge CLK);
        #1;
        check("pre_reset_value", 8'h03, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        check("async_reset_clear", 8'h00, 1'b1);
        @(posedge CLK);
        #1;
        check("reset_held_over_edge", 8'h00, 1'b1);
        @(negedge CLK);
        RST_N = 1'b1;
        #1;
        check("after_release_before_edge", 8'h00, 1'b1);
        @(posedge CLK);
        #1;
        check("first_capture_after_release", 8'h03, 1'b0);

        // Back-to-back alternating ADD/SUB with no bubbles.
        exp_q.delete();
        for (int i = 0; i < 12; i++) begin
            logic [7:0] a, b;
            logic [4:0] op;
            a  = 8'($urandom);
            b  = 8'($urandom);
            op = (i % 2 == 0) ? 5'b00000 : 5'b00001;
            @(negedge CLK);
            if (i > 0) begin
                e = exp_q.pop_front();
                check("b2b_addsub", e, e == 8'h00);
            end
            OP    = op;
            inOne = a;
            inTwo = b;
            exp_q.push_back(ref_alu(op, a, b));
        end
        @(negedge CLK);
        e = exp_q.pop_front();
        check("b2b_addsub_last", e, e == 8'h00);

        // Randomized stimulus against the reference model, one op per cycle.
        exp_q.delete();
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a, b;
            logic [4:0] op;
            op = 5'($urandom);
            a  = 8'($urandom);
            case ($urandom_range(0, 3))
                0:       b = 8'($urandom_range(0, 9));
                1:       b = 8'h00;
                default: b = 8'($urandom);
            endcase
            @(negedge CLK);
            if (i > 0) begin
                e = exp_q.pop_front();
                check("random", e, e == 8'h00);
            end
            OP    = op;
            inOne = a;
            inTwo = b;
            exp_q.push_back(ref_alu(op, a, b));
        end
        @(negedge CLK);
        e = exp_q.pop_front();
        check("random_last", e, e == 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
